// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin memory arbiter.
package common_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  localparam int MAX_DATA_WIDTH = 1024;

  // All-ones response word of the requested width, returned on a watchdog timeout.
  function automatic logic [MAX_DATA_WIDTH-1:0] resp_timeout_data(input int width);
    return {MAX_DATA_WIDTH{1'b1}} >> (MAX_DATA_WIDTH - width);
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first set request bit at or above ptr_i, wrapping to 0.
module rr_pick
  import common_pkg::*;
#(
  parameter int NUM_USERS = 4,
  parameter int IDX_W     = $clog2(NUM_USERS)
) (
  input  logic [NUM_USERS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic                 found_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic [IDX_W:0] cand;

  // Walk from the farthest offset down so the nearest requester is the last one written.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = NUM_USERS - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_i} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(NUM_USERS)) begin
        cand = cand - (IDX_W + 1)'(NUM_USERS);
      end else begin
        cand = cand;
      end
      if (req_i[cand[IDX_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[IDX_W-1:0];
      end else begin
        found_o = found_o;
        idx_o   = idx_o;
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory channel between NUM_USERS requesters.
// Optional response watchdog enabled by defining MEM_RR_ARBITER_WATCHDOG_EN.
module mem_rr_arbiter
  import common_pkg::*;
#(
  parameter int NUM_USERS      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WE_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_USERS-1:0]             req_valid,
  output logic [NUM_USERS-1:0]             req_ready,
  input  logic [NUM_USERS*WE_WIDTH-1:0]    req_we,
  input  logic [NUM_USERS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_USERS*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_USERS-1:0]             resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_data,
  output logic                             mem_valid,
  input  logic                             mem_ready,
  output logic [WE_WIDTH-1:0]              mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_data,
  input  logic                             mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]            mem_resp_data,
  output logic                             busy,
  output logic                             timeout_err
);

  localparam int IDX_W = $clog2(NUM_USERS);

  arb_state_t             state_q;
  logic [IDX_W-1:0]       prio_q, prio_d, owner_q, pick_idx;
  logic                   pick_found, grant;
  logic [NUM_USERS-1:0]   resp_valid_q;
  logic [DATA_WIDTH-1:0]  resp_data_q, mem_data_q, data_sel;
  logic                   mem_valid_q;
  logic [WE_WIDTH-1:0]    mem_we_q, we_sel;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, addr_sel;

  rr_pick #(.NUM_USERS(NUM_USERS), .IDX_W(IDX_W)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (prio_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Gating with reset keeps req_ready low while reset is held, even with requests pending.
  assign grant    = reset && (state_q == ST_IDLE) && pick_found;
  assign we_sel   = req_we[pick_idx*WE_WIDTH +: WE_WIDTH];
  assign addr_sel = req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign data_sel = req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[pick_idx] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  always_comb begin
    if (owner_q == IDX_W'(NUM_USERS - 1)) begin
      prio_d = '0;
    end else begin
      prio_d = owner_q + IDX_W'(1);
    end
  end

`ifdef MEM_RR_ARBITER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DATA_WIDTH-1:0] RESP_TIMEOUT_DATA =
    DATA_WIDTH'(resp_timeout_data(DATA_WIDTH));
  logic [WD_W-1:0] wd_cnt_q;
  logic            timeout_err_q;
  logic            wd_expired;
  assign wd_expired  = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Arbiter FSM with registered memory-side and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      prio_q       <= '0;
      owner_q      <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
`ifdef MEM_RR_ARBITER_WATCHDOG_EN
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      resp_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            owner_q     <= pick_idx;
            mem_we_q    <= we_sel;
            mem_addr_q  <= {2'b00, addr_sel[ADDR_WIDTH-1:2]};
            mem_data_q  <= data_sel;
            mem_valid_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            state_q     <= ST_WAIT;
`ifdef MEM_RR_ARBITER_WATCHDOG_EN
            wd_cnt_q    <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            resp_data_q           <= mem_resp_data;
            resp_valid_q[owner_q] <= 1'b1;
            prio_q                <= prio_d;
            state_q               <= ST_IDLE;
          end
`ifdef MEM_RR_ARBITER_WATCHDOG_EN
          else if (wd_expired) begin
            resp_data_q           <= RESP_TIMEOUT_DATA;
            resp_valid_q[owner_q] <= 1'b1;
            timeout_err_q         <= 1'b1;
            prio_q                <= prio_d;
            state_q               <= ST_IDLE;
          end else begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign mem_valid  = mem_valid_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
